// File: rtl/dfr_sequencer.sv
// Phase sequencer for the DFR core: walks init/train/test phases, feeds one
// input sample per reservoir step and routes states to memory or the accumulator.
module dfr_sequencer #(
    parameter int VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           num_init_samples,
    input  logic [31:0]           num_train_samples,
    input  logic [31:0]           num_test_samples,
    input  logic [31:0]           num_steps_per_sample,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            phase,
    output logic                  in_mem_rd,
    output logic [ADDR_WIDTH-1:0] in_mem_addr,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
    output logic                  w_mem_rd,
    output logic [ADDR_WIDTH-1:0] w_mem_addr,
    input  logic [DATA_WIDTH-1:0] w_mem_rdata,
    output logic                  res_in_valid,
    output logic [DATA_WIDTH-1:0] res_in_data,
    input  logic                  res_in_ready,
    input  logic                  res_out_valid,
    input  logic [DATA_WIDTH-1:0] res_out_data,
    output logic                  rs_mem_wr,
    output logic [ADDR_WIDTH-1:0] rs_mem_addr,
    output logic [DATA_WIDTH-1:0] rs_mem_wdata,
    output logic                  out_mem_wr,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [DATA_WIDTH-1:0] out_mem_wdata
);

    if (VIRTUAL_NODES < 1) begin : g_bad_nodes
        $error("dfr_sequencer: VIRTUAL_NODES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_RES,
        S_STORE,
        S_WRITE_OUT,
        S_DONE
    } state_t;

    localparam logic [1:0] PH_NONE  = 2'd0;
    localparam logic [1:0] PH_INIT  = 2'd1;
    localparam logic [1:0] PH_TRAIN = 2'd2;
    localparam logic [1:0] PH_TEST  = 2'd3;

    state_t                state_q, state_d;
    logic [1:0]            phase_q;
    logic [31:0]           n_init_q, n_train_q, n_test_q, n_steps_q;
    logic [31:0]           s_q, k_q;
    logic [ADDR_WIDTH-1:0] ia_q, ra_q;
    logic [DATA_WIDTH-1:0] acc_q, sample_q, weight_q, res_q;
    logic                  fresh_q;

    logic [1:0]            first_phase, next_phase;
    logic [31:0]           phase_cnt;
    logic                  last_step, last_sample, sample_end;
    logic [DATA_WIDTH-1:0] prod, cur_sample;

    // Lowest-numbered non-empty phase strictly after 'after'; 0 means none left.
    function automatic logic [1:0] pick_phase(input logic [1:0] after,
                                              input logic [31:0] ni, nt, nx, ns);
        logic [1:0] p;
        p = PH_NONE;
        if (ns != 32'd0) begin
            if (after < PH_TEST  && nx != 32'd0) p = PH_TEST;
            if (after < PH_TRAIN && nt != 32'd0) p = PH_TRAIN;
            if (after < PH_INIT  && ni != 32'd0) p = PH_INIT;
        end
        return p;
    endfunction

    always_comb begin
        first_phase = pick_phase(PH_NONE, num_init_samples, num_train_samples,
                                 num_test_samples, num_steps_per_sample);
        next_phase  = pick_phase(phase_q, n_init_q, n_train_q, n_test_q, n_steps_q);
        case (phase_q)
            PH_INIT:  phase_cnt = n_init_q;
            PH_TRAIN: phase_cnt = n_train_q;
            PH_TEST:  phase_cnt = n_test_q;
            default:  phase_cnt = 32'd0;
        endcase
        last_step   = (s_q == n_steps_q - 32'd1);
        last_sample = (k_q == phase_cnt - 32'd1);
        sample_end  = (state_q == S_STORE && last_step && phase_q != PH_TEST) ||
                      (state_q == S_WRITE_OUT);
        prod        = res_q * weight_q;
        // Read data is only valid in the first ISSUE cycle; afterwards the copy holds it.
        cur_sample  = fresh_q ? in_mem_rdata : sample_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_NONE;
            n_init_q  <= '0;
            n_train_q <= '0;
            n_test_q  <= '0;
            n_steps_q <= '0;
            s_q       <= '0;
            k_q       <= '0;
            ia_q      <= '0;
            ra_q      <= '0;
            acc_q     <= '0;
            sample_q  <= '0;
            weight_q  <= '0;
            res_q     <= '0;
            fresh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fresh_q <= (state_q == S_FETCH);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_init_q  <= num_init_samples;
                        n_train_q <= num_train_samples;
                        n_test_q  <= num_test_samples;
                        n_steps_q <= num_steps_per_sample;
                        phase_q   <= first_phase;
                        s_q       <= '0;
                        k_q       <= '0;
                        ia_q      <= '0;
                        ra_q      <= '0;
                        acc_q     <= '0;
                    end
                end
                S_ISSUE: begin
                    if (fresh_q) begin
                        sample_q <= in_mem_rdata;
                        weight_q <= w_mem_rdata;
                    end
                end
                S_WAIT_RES: begin
                    if (res_out_valid) res_q <= res_out_data;
                end
                S_STORE: begin
                    ia_q <= ia_q + 1'b1;
                    if (phase_q == PH_TRAIN) ra_q <= ra_q + 1'b1;
                    if (phase_q == PH_TEST) acc_q <= acc_q + prod;
                    s_q <= last_step ? 32'd0 : s_q + 32'd1;
                end
                S_WRITE_OUT: acc_q <= '0;
                default: ;
            endcase
            if (sample_end) begin
                if (last_sample) begin
                    k_q     <= '0;
                    phase_q <= next_phase;
                end else begin
                    k_q <= k_q + 32'd1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;
        phase         = phase_q;
        in_mem_rd     = 1'b0;
        in_mem_addr   = '0;
        w_mem_rd      = 1'b0;
        w_mem_addr    = '0;
        res_in_valid  = 1'b0;
        res_in_data   = '0;
        rs_mem_wr     = 1'b0;
        rs_mem_addr   = '0;
        rs_mem_wdata  = '0;
        out_mem_wr    = 1'b0;
        out_mem_addr  = '0;
        out_mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (first_phase != PH_NONE) ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
                in_mem_rd   = 1'b1;
                in_mem_addr = ia_q;
                if (phase_q == PH_TEST) begin
                    w_mem_rd   = 1'b1;
                    w_mem_addr = s_q[ADDR_WIDTH-1:0];
                end
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                res_in_valid = 1'b1;
                res_in_data  = cur_sample;
                if (res_in_ready) state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (res_out_valid) state_d = S_STORE;
            end
            S_STORE: begin
                if (phase_q == PH_TRAIN) begin
                    rs_mem_wr    = 1'b1;
                    rs_mem_addr  = ra_q;
                    rs_mem_wdata = res_q;
                end
                if (!last_step)              state_d = S_FETCH;
                else if (phase_q == PH_TEST) state_d = S_WRITE_OUT;
                else if (!last_sample)       state_d = S_FETCH;
                else                         state_d = (next_phase != PH_NONE) ? S_FETCH : S_DONE;
            end
            S_WRITE_OUT: begin
                out_mem_wr    = 1'b1;
                out_mem_addr  = k_q[ADDR_WIDTH-1:0];
                out_mem_wdata = acc_q;
                if (!last_sample) state_d = S_FETCH;
                else              state_d = (next_phase != PH_NONE) ? S_FETCH : S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dfr_sequencer.sv
// Self-checking bench for dfr_sequencer: memory and reservoir models plus a
// phase-level reference that predicts every read address and memory write.
module tb_dfr_sequencer;
    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   ni_s = '0, nt_s = '0, nx_s = '0, ns_s = '0;
    logic          busy, done;
    logic [1:0]    phase;
    logic          in_mem_rd, w_mem_rd, res_in_valid, rs_mem_wr, out_mem_wr;
    logic [AW-1:0] in_mem_addr, w_mem_addr, rs_mem_addr, out_mem_addr;
    logic [DW-1:0] in_mem_rdata = '0, w_mem_rdata = '0, res_in_data, res_out_data = '0;
    logic [DW-1:0] rs_mem_wdata, out_mem_wdata;
    logic          res_in_ready = 1'b1, res_out_valid = 1'b0;

    dfr_sequencer #(.VIRTUAL_NODES(10), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .num_init_samples(ni_s), .num_train_samples(nt_s),
        .num_test_samples(nx_s), .num_steps_per_sample(ns_s),
        .busy(busy), .done(done), .phase(phase),
        .in_mem_rd(in_mem_rd), .in_mem_addr(in_mem_addr), .in_mem_rdata(in_mem_rdata),
        .w_mem_rd(w_mem_rd), .w_mem_addr(w_mem_addr), .w_mem_rdata(w_mem_rdata),
        .res_in_valid(res_in_valid), .res_in_data(res_in_data), .res_in_ready(res_in_ready),
        .res_out_valid(res_out_valid), .res_out_data(res_out_data),
        .rs_mem_wr(rs_mem_wr), .rs_mem_addr(rs_mem_addr), .rs_mem_wdata(rs_mem_wdata),
        .out_mem_wr(out_mem_wr), .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] imem [256];
    logic [DW-1:0] wmem [16];
    logic [DW-1:0] rmul = 32'd1, radd = 32'd0;
    bit            stall_mode = 1'b0;

    bit            pend = 1'b0, stalled = 1'b0, prev_rd = 1'b0, prev_wrd = 1'b0;
    bit            prev_rs = 1'b0, prev_out = 1'b0;
    int            cnt = 0;
    logic [DW-1:0] pd = '0, held = '0;
    logic [AW-1:0] prev_a = '0, prev_wa = '0;

    logic [AW-1:0] mon_rd[$], mon_rs_a[$], mon_out_a[$];
    logic [DW-1:0] mon_rs_d[$], mon_out_d[$];
    logic [1:0]    mon_phase[$];
    logic [1:0]    last_phase = 2'd0;
    int            done_cnt = 0, busy_cnt = 0, stab_err = 0, wr_err = 0, strobe_cnt = 0;

    logic [AW-1:0] exp_rd[$], exp_rs_a[$], exp_out_a[$];
    logic [DW-1:0] exp_rs_d[$], exp_out_d[$];
    logic [1:0]    exp_phase[$];

    // Environment: registered memories (1-cycle latency), reservoir with random
    // response delay, and a monitor recording what the DUT did each cycle.
    always @(negedge clk) begin
        if (pend && cnt == 0) begin
            res_out_valid = 1'b1;
            res_out_data  = pd;
            pend          = 1'b0;
        end else begin
            res_out_valid = 1'b0;
            res_out_data  = $urandom;
            if (pend) cnt = cnt - 1;
        end
        res_in_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        in_mem_rdata = prev_rd  ? imem[prev_a[7:0]]  : $urandom;
        w_mem_rdata  = prev_wrd ? wmem[prev_wa[3:0]] : $urandom;
        #1;
        prev_rd  = in_mem_rd;
        prev_a   = in_mem_addr;
        prev_wrd = w_mem_rd;
        prev_wa  = w_mem_addr;
        if (res_in_valid && res_in_ready) begin
            pend = 1'b1;
            cnt  = stall_mode ? int'($urandom_range(0, 5)) : 0;
            pd   = res_in_data * rmul + radd;
        end
        if (stalled && res_in_valid && res_in_data !== held) stab_err++;
        stalled = res_in_valid && !res_in_ready;
        held    = res_in_data;
        if (rst) begin
            pend    = 1'b0;
            stalled = 1'b0;
        end
        if (in_mem_rd) mon_rd.push_back(in_mem_addr);
        if (rs_mem_wr) begin
            mon_rs_a.push_back(rs_mem_addr);
            mon_rs_d.push_back(rs_mem_wdata);
        end
        if (out_mem_wr) begin
            mon_out_a.push_back(out_mem_addr);
            mon_out_d.push_back(out_mem_wdata);
        end
        if (rs_mem_wr && out_mem_wr) wr_err++;
        if ((rs_mem_wr && prev_rs) || (out_mem_wr && prev_out)) wr_err++;
        prev_rs  = rs_mem_wr;
        prev_out = out_mem_wr;
        strobe_cnt += int'(in_mem_rd) + int'(w_mem_rd) + int'(rs_mem_wr) + int'(out_mem_wr);
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (phase != last_phase && phase != 2'd0) mon_phase.push_back(phase);
        last_phase = phase;
    end

    task automatic clear_mon();
        mon_rd.delete(); mon_rs_a.delete(); mon_rs_d.delete();
        mon_out_a.delete(); mon_out_d.delete(); mon_phase.delete();
        done_cnt = 0; busy_cnt = 0; stab_err = 0; wr_err = 0; strobe_cnt = 0;
    endtask

    // Reference: the run is a sequence of phases, samples and steps over a global input index.
    task automatic build_expected(input int ni, input int nt, input int nx, input int ns);
        int            ia, ra, n;
        logic [DW-1:0] acc, y;
        exp_rd.delete(); exp_rs_a.delete(); exp_rs_d.delete();
        exp_out_a.delete(); exp_out_d.delete(); exp_phase.delete();
        ia = 0;
        ra = 0;
        if (ns == 0) return;
        for (int p = 1; p <= 3; p++) begin
            n = (p == 1) ? ni : (p == 2) ? nt : nx;
            if (n > 0) exp_phase.push_back(2'(p));
            for (int k = 0; k < n; k++) begin
                acc = '0;
                for (int s = 0; s < ns; s++) begin
                    y = imem[ia % 256] * rmul + radd;
                    exp_rd.push_back(AW'(ia));
                    if (p == 2) begin
                        exp_rs_a.push_back(AW'(ra));
                        exp_rs_d.push_back(y);
                        ra++;
                    end
                    if (p == 3) acc = acc + y * wmem[s];
                    ia++;
                end
                if (p == 3) begin
                    exp_out_a.push_back(AW'(k));
                    exp_out_d.push_back(acc);
                end
            end
        end
    endtask

    function automatic int diff_results();
        int d = 0;
        if (mon_rd.size() != exp_rd.size()) d++;
        else foreach (exp_rd[i]) if (mon_rd[i] !== exp_rd[i]) d++;
        if (mon_rs_a.size() != exp_rs_a.size()) d++;
        else foreach (exp_rs_a[i]) if (mon_rs_a[i] !== exp_rs_a[i] || mon_rs_d[i] !== exp_rs_d[i]) d++;
        if (mon_out_a.size() != exp_out_a.size()) d++;
        else foreach (exp_out_a[i]) if (mon_out_a[i] !== exp_out_a[i] || mon_out_d[i] !== exp_out_d[i]) d++;
        if (mon_phase.size() != exp_phase.size()) d++;
        else foreach (exp_phase[i]) if (mon_phase[i] !== exp_phase[i]) d++;
        return d;
    endfunction

    function automatic bit outs_zero();
        return {busy, done, phase, in_mem_rd, in_mem_addr, w_mem_rd, w_mem_addr,
                res_in_valid, res_in_data, rs_mem_wr, rs_mem_addr, rs_mem_wdata,
                out_mem_wr, out_mem_addr, out_mem_wdata} == '0;
    endfunction

    // Launches a run and returns the cycle count from the start cycle to done, inclusive.
    task automatic run_dfr(input int ni, input int nt, input int nx, input int ns,
                           input int inject_at, output int cycles, output bit timed_out);
        int c;
        @(negedge clk);
        clear_mon();
        build_expected(ni, nt, nx, ns);
        ni_s = ni; nt_s = nt; nx_s = nx; ns_s = ns;
        start = 1'b1;
        c = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            c++;
            start = (c == inject_at);
            if (start) begin
                ni_s = $urandom_range(0, 4); nt_s = $urandom_range(0, 4);
                nx_s = $urandom_range(0, 4); ns_s = $urandom_range(0, 4);
            end
            #2;
            if (done) break;
            if (c > 5000) begin
                timed_out = 1'b1;
                break;
            end
        end
        start = 1'b0;
        cycles = c + 1;
        @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        int bad = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        n_tests++;
        if (!outs_zero()) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b phase=%0d in_rd=%0b, required all zero", busy, phase, in_mem_rd);
        end
        repeat (20) begin
            @(negedge clk);
            #2;
            if (!outs_zero()) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_outputs: %0d non-zero cycles, required 0", bad);
        end
    endtask

    task automatic test_test_only();
        int cyc;
        bit to;
        for (int i = 0; i < 256; i++) imem[i] = DW'(i) * 32'd85899345;
        for (int i = 0; i < 16; i++) wmem[i] = 32'd1;
        rmul = 32'd1; radd = 32'd0; stall_mode = 1'b0;
        run_dfr(0, 0, 5, 10, 0, cyc, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL test_only_timeout: no done within bound"); end
        n_tests++;
        if (mon_out_a.size() != 5) begin
            n_fail++; $display("FAIL test_only_out_count: got %0d required 5", mon_out_a.size());
        end
        n_tests++;
        if (diff_results() != 0) begin
            n_fail++; $display("FAIL test_only_results: %0d discrepancies, required 0", diff_results());
        end
        n_tests++;
        if (mon_out_d.size() == 0 || mon_out_d[0] !== 32'd3865470525) begin
            n_fail++; $display("FAIL test_only_first_sum: got %0h required %0h",
                               (mon_out_d.size() != 0) ? mon_out_d[0] : 32'hx, 32'd3865470525);
        end
        n_tests++;
        if (mon_rd.size() != 50 || mon_rd[49] !== 16'd49) begin
            n_fail++; $display("FAIL test_only_reads: got %0d reads required 50 ending at 49", mon_rd.size());
        end
        n_tests++;
        if (done_cnt != 1 || cyc != 1 + 50 * 4 + 5 + 1) begin
            n_fail++; $display("FAIL test_only_timing: done=%0d cycles=%0d required done=1 cycles=%0d",
                               done_cnt, cyc, 1 + 50 * 4 + 5 + 1);
        end
    endtask

    task automatic test_all_phases();
        int cyc;
        bit to;
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        for (int i = 0; i < 16; i++) wmem[i] = $urandom;
        rmul = 32'd3; radd = 32'd5; stall_mode = 1'b0;
        run_dfr(2, 3, 1, 4, 0, cyc, to);
        n_tests++;
        if (to || mon_rs_a.size() != 12 || mon_rs_a[11] !== 16'd11) begin
            n_fail++; $display("FAIL phases_rs_writes: got %0d writes required 12 at 0..11", mon_rs_a.size());
        end
        n_tests++;
        if (mon_rd.size() != 24 || mon_rd[23] !== 16'd23) begin
            n_fail++; $display("FAIL phases_reads: got %0d reads required 24 at 0..23", mon_rd.size());
        end
        n_tests++;
        if (mon_phase.size() != 3 || mon_phase[0] != 2'd1 || mon_phase[1] != 2'd2 || mon_phase[2] != 2'd3) begin
            n_fail++; $display("FAIL phases_sequence: got %0d phase entries required 1,2,3", mon_phase.size());
        end
        n_tests++;
        if (mon_out_a.size() != 1 || diff_results() != 0) begin
            n_fail++; $display("FAIL phases_results: out=%0d diffs=%0d required out=1 diffs=0",
                               mon_out_a.size(), diff_results());
        end
        n_tests++;
        if (cyc != 1 + 24 * 4 + 1 + 1 || wr_err != 0) begin
            n_fail++; $display("FAIL phases_timing: cycles=%0d wr_err=%0d required %0d and 0",
                               cyc, wr_err, 1 + 24 * 4 + 1 + 1);
        end
    endtask

    task automatic test_backpressure();
        int cyc, ni, nt, nx, ns;
        bit to;
        logic [DW-1:0] ref_out[$];
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 256; i++) imem[i] = $urandom;
            for (int i = 0; i < 16; i++) wmem[i] = $urandom;
            rmul = $urandom | 32'd1; radd = $urandom;
            ni = $urandom_range(0, 2); nt = $urandom_range(2, 3);
            nx = $urandom_range(1, 3); ns = $urandom_range(2, 5);
            stall_mode = 1'b0;
            run_dfr(ni, nt, nx, ns, 0, cyc, to);
            ref_out = mon_out_d;
            n_tests++;
            if (to || diff_results() != 0) begin
                n_fail++; $display("FAIL bp_nostall_%0d: diffs=%0d timeout=%0b required 0", it, diff_results(), to);
            end
            stall_mode = 1'b1;
            run_dfr(ni, nt, nx, ns, int'($urandom_range(3, 12)), cyc, to);
            stall_mode = 1'b0;
            n_tests++;
            if (to || diff_results() != 0 || mon_out_d != ref_out) begin
                n_fail++; $display("FAIL bp_stall_%0d: diffs=%0d timeout=%0b required 0", it, diff_results(), to);
            end
            n_tests++;
            if (stab_err != 0 || wr_err != 0 || done_cnt != 1) begin
                n_fail++; $display("FAIL bp_protocol_%0d: stab=%0d wr=%0d done=%0d required 0,0,1",
                                   it, stab_err, wr_err, done_cnt);
            end
        end
    endtask

    task automatic test_empty();
        int cyc;
        bit to;
        for (int it = 0; it < 2; it++) begin
            if (it == 0) run_dfr(0, 0, 0, 0, 0, cyc, to);
            else         run_dfr(3, 2, 1, 0, 0, cyc, to);
            n_tests++;
            if (to || busy_cnt != 1 || done_cnt != 1 || strobe_cnt != 0 || cyc != 2) begin
                n_fail++; $display("FAIL empty_%0d: busy=%0d done=%0d strobes=%0d cycles=%0d required 1,1,0,2",
                                   it, busy_cnt, done_cnt, strobe_cnt, cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c = 0, cyc;
        bit to;
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        for (int i = 0; i < 16; i++) wmem[i] = $urandom;
        rmul = 32'd1; radd = 32'd0;
        @(negedge clk);
        clear_mon();
        ni_s = 0; nt_s = 0; nx_s = 3; ns_s = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (mon_out_a.size() == 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        n_tests++;
        if (!outs_zero() || done_cnt != 0 || c >= 200) begin
            n_fail++; $display("FAIL reset_mid: busy=%0b done_cnt=%0d wait=%0d required 0,0,<200", busy, done_cnt, c);
        end
        run_dfr(1, 1, 2, 3, 0, cyc, to);
        n_tests++;
        if (to || diff_results() != 0 || mon_rd.size() == 0 || mon_rd[0] !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid_restart: diffs=%0d timeout=%0b required 0", diff_results(), to);
        end
    endtask

    initial begin
        test_reset();
        test_test_only();
        test_all_phases();
        test_backpressure();
        test_empty();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
